// File: rtl/alu_decode_muldiv_pkg.sv
// alu_pkg: opcode, funct and ALU-select encodings plus the mul/div engine state type
// shared by the EX-stage ALU control and its iterative mul/div unit.
package alu_pkg;

   localparam logic [3:0] ALUOP_ADD   = 4'b0000;
   localparam logic [3:0] ALUOP_SUB   = 4'b0001;
   localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
   localparam logic [3:0] ALUOP_AND   = 4'b0011;
   localparam logic [3:0] ALUOP_OR    = 4'b0100;
   localparam logic [3:0] ALUOP_SLT   = 4'b0101;
   localparam logic [3:0] ALUOP_XOR   = 4'b0110;
   localparam logic [3:0] ALUOP_SLTU  = 4'b0111;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   localparam logic [3:0] AC_AND     = 4'b0000;
   localparam logic [3:0] AC_OR      = 4'b0001;
   localparam logic [3:0] AC_XOR     = 4'b0010;
   localparam logic [3:0] AC_NOR     = 4'b0011;
   localparam logic [3:0] AC_ADD     = 4'b0100;
   localparam logic [3:0] AC_SUB     = 4'b0101;
   localparam logic [3:0] AC_SLT     = 4'b0110;
   localparam logic [3:0] AC_SLTU    = 4'b0111;
   localparam logic [3:0] AC_SLL     = 4'b1000;
   localparam logic [3:0] AC_SRL     = 4'b1001;
   localparam logic [3:0] AC_SRA     = 4'b1010;
   localparam logic [3:0] AC_PASS_HI = 4'b1011;
   localparam logic [3:0] AC_PASS_LO = 4'b1100;
   localparam logic [3:0] AC_NONE    = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } md_state_e;

   // R-type functs that touch HI/LO or the engine and so must wait for it
   function automatic logic is_md_funct(input logic [5:0] f);
      return f inside {F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
   endfunction

endpackage

// File: rtl/alu_decode_muldiv_if.sv
// EX-stage bus between the pipeline and the ALU control / HI-LO block.
// master = pipeline side, slave = alu_decode_muldiv.
interface alu_decode_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             valid;
   logic             flush;
   logic [3:0]       aluop;
   logic [5:0]       funct;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [3:0]       alucontrol;
   logic             illegal;
   logic             md_stall;
   logic             md_busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output valid, flush, aluop, funct, src_a, src_b,
      input  alucontrol, illegal, md_stall, md_busy, hi, lo
   );

   modport slave (
      input  valid, flush, aluop, funct, src_a, src_b,
      output alucontrol, illegal, md_stall, md_busy, hi, lo
   );
endinterface

// File: rtl/alu_decode_muldiv_md_iter_unit.sv
// md_iter_unit: one-bit-per-cycle shift-add multiplier / restoring divider on operand
// magnitudes, with a down-counter and sign fixup applied to the final step's result.
//
//   state | meaning
//   IDLE  | waiting for start_i; counter parked at 0
//   MUL   | shift-add multiply, one multiplier bit per cycle
//   DIV   | restoring divide, one quotient bit per cycle
module md_iter_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             is_div_i,
   input  logic             is_signed_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, opb_q, opb_d;
   logic             negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

   logic             sign_a, sign_b, last;
   logic [WIDTH-1:0] mag_a, mag_b, acc_nx, mq_nx;
   logic [WIDTH:0]   mul_sum, div_shift;
   logic [2*WIDTH-1:0] prod;

   assign sign_a = is_signed_i & a_i[WIDTH-1];
   assign sign_b = is_signed_i & b_i[WIDTH-1];
   assign mag_a  = sign_a ? -a_i : a_i;
   assign mag_b  = sign_b ? -b_i : b_i;
   assign last   = (cnt_q == CNT_W'(1));
   assign busy_o = (state_q != IDLE);
   assign done_o = busy_o & last & ~flush_i;

   // acc holds the running high half (MUL) or partial remainder (DIV); mq the multiplier / quotient
   always_comb begin
      acc_nx    = acc_q;
      mq_nx     = mq_q;
      mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {acc_q, mq_q[WIDTH-1]};
      if (state_q == DIV) begin
         if (div_shift >= {1'b0, opb_q}) begin
            acc_nx = div_shift[WIDTH-1:0] - opb_q;
            mq_nx  = {mq_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx = div_shift[WIDTH-1:0];
            mq_nx  = {mq_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         {acc_nx, mq_nx} = {mul_sum, mq_q[WIDTH-1:1]};
      end
   end

   assign prod = {acc_nx, mq_nx};

   // Divide-by-zero: negr reconstructs the raw dividend from its magnitude for hi
   always_comb begin
      hi_o = '0;
      lo_o = '0;
      if (state_q == DIV) begin
         hi_o = negr_q ? -acc_nx : acc_nx;
         if (dz_q)
            lo_o = '1;
         else
            lo_o = negq_q ? -mq_nx : mq_nx;
      end else begin
         {hi_o, lo_o} = negq_q ? -prod : prod;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      opb_d   = opb_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = is_div_i ? DIV : MUL;
               cnt_d   = CNT_W'(WIDTH);
               acc_d   = '0;
               mq_d    = is_div_i ? mag_a : mag_b;
               opb_d   = is_div_i ? mag_b : mag_a;
               negq_d  = sign_a ^ sign_b;
               negr_d  = sign_a;
               dz_d    = (b_i == '0);
            end
         end
         MUL, DIV: begin
            if (flush_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = acc_nx;
               mq_d  = mq_nx;
               cnt_d = cnt_q - CNT_W'(1);
               if (last)
                  state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         opb_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         opb_q   <= opb_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: rtl/alu_decode_muldiv.sv
// alu_decode_muldiv: EX-stage aluop/funct decode, HI/LO registers, mul/div stall and flush.
// Build macro FAST_MUL_EN: mult/multu complete in one cycle; divides stay iterative.
module alu_decode_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic                clk,
   input logic                rst_n,
   alu_decode_muldiv_if.slave bus
);

   logic [3:0]       alucontrol;
   logic             aluop_ok, funct_ok;
   logic             rtype, f_mul, f_div, f_mthi, f_mtlo, f_signed, accept;
   logic             md_busy, md_done, iter_start;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;

   always_comb begin
      alucontrol = AC_NONE;
      aluop_ok   = 1'b1;
      funct_ok   = 1'b1;
      case (bus.aluop)
         ALUOP_ADD:  alucontrol = AC_ADD;
         ALUOP_SUB:  alucontrol = AC_SUB;
         ALUOP_AND:  alucontrol = AC_AND;
         ALUOP_OR:   alucontrol = AC_OR;
         ALUOP_SLT:  alucontrol = AC_SLT;
         ALUOP_XOR:  alucontrol = AC_XOR;
         ALUOP_SLTU: alucontrol = AC_SLTU;
         ALUOP_RTYPE: begin
            case (bus.funct)
               F_ADD, F_ADDU: alucontrol = AC_ADD;
               F_SUB, F_SUBU: alucontrol = AC_SUB;
               F_AND:         alucontrol = AC_AND;
               F_OR:          alucontrol = AC_OR;
               F_XOR:         alucontrol = AC_XOR;
               F_NOR:         alucontrol = AC_NOR;
               F_SLT:         alucontrol = AC_SLT;
               F_SLTU:        alucontrol = AC_SLTU;
               F_SLL:         alucontrol = AC_SLL;
               F_SRL:         alucontrol = AC_SRL;
               F_SRA:         alucontrol = AC_SRA;
               F_MFHI:        alucontrol = AC_PASS_HI;
               F_MFLO:        alucontrol = AC_PASS_LO;
               F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU:
                              alucontrol = AC_NONE;
               default:       funct_ok   = 1'b0;
            endcase
         end
         default: aluop_ok = 1'b0;
      endcase
   end

   assign rtype    = (bus.aluop == ALUOP_RTYPE);
   assign f_mul    = rtype & ((bus.funct == F_MULT) | (bus.funct == F_MULTU));
   assign f_div    = rtype & ((bus.funct == F_DIV)  | (bus.funct == F_DIVU));
   assign f_mthi   = rtype & (bus.funct == F_MTHI);
   assign f_mtlo   = rtype & (bus.funct == F_MTLO);
   assign f_signed = ~bus.funct[0];
   assign accept   = bus.valid & ~bus.flush & ~md_busy;

`ifdef FAST_MUL_EN
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
   assign ext_a      = {{WIDTH{f_signed & bus.src_a[WIDTH-1]}}, bus.src_a};
   assign ext_b      = {{WIDTH{f_signed & bus.src_b[WIDTH-1]}}, bus.src_b};
   // the low 2*WIDTH bits of the sign-extended product are the exact signed/unsigned result
   assign fast_prod  = ext_a * ext_b;
   assign iter_start = accept & f_div;
`else
   assign iter_start = accept & (f_mul | f_div);
`endif

   md_iter_unit #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_md_iter (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (iter_start),
      .is_div_i    (f_div),
      .is_signed_i (f_signed),
      .flush_i     (bus.flush),
      .a_i         (bus.src_a),
      .b_i         (bus.src_b),
      .busy_o      (md_busy),
      .done_o      (md_done),
      .hi_o        (res_hi),
      .lo_o        (res_lo)
   );

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (md_done) begin
         hi_d = res_hi;
         lo_d = res_lo;
      end else if (accept & f_mthi) begin
         hi_d = bus.src_a;
      end else if (accept & f_mtlo) begin
         lo_d = bus.src_a;
`ifdef FAST_MUL_EN
      end else if (accept & f_mul) begin
         {hi_d, lo_d} = fast_prod;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign bus.alucontrol = alucontrol;
   assign bus.illegal    = bus.valid & ~(aluop_ok & funct_ok);
   assign bus.md_stall   = md_busy & bus.valid & rtype & is_md_funct(bus.funct);
   assign bus.md_busy    = md_busy;
   assign bus.hi         = hi_q;
   assign bus.lo         = lo_q;

endmodule

// File: tb/tb_alu_decode_muldiv.sv
// tb_alu_decode_muldiv: decode vector table plus directed mul/div, HI/LO move,
// flush, back-to-back and async-reset sequences with hand-computed results.
module tb_alu_decode_muldiv;

   localparam int W = 32;
`ifdef FAST_MUL_EN
   localparam int MUL_CYC = 0;
`else
   localparam int MUL_CYC = W;
`endif
   localparam int DIV_CYC = W;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef struct packed {
      logic       valid;
      logic [3:0] aluop;
      logic [5:0] funct;
      logic [3:0] ac;
      logic       ill;
   } dec_vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   alu_decode_muldiv_if #(.WIDTH(W)) ifc ();

   alu_decode_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic dec_vec_t mk(input logic v, input logic [3:0] op, input logic [5:0] f,
                                   input logic [3:0] ac, input logic ill);
      dec_vec_t d;
      d.valid = v;
      d.aluop = op;
      d.funct = f;
      d.ac    = ac;
      d.ill   = ill;
      return d;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_bus();
      ifc.valid = 1'b0;
      ifc.flush = 1'b0;
      ifc.aluop = 4'b0000;
      ifc.funct = 6'b000000;
      ifc.src_a = '0;
      ifc.src_b = '0;
   endtask

   task automatic drive_r(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      ifc.valid = 1'b1;
      ifc.aluop = 4'b0010;
      ifc.funct = f;
      ifc.src_a = a;
      ifc.src_b = b;
   endtask

   task automatic wait_idle(input string name, output int cyc);
      cyc = 0;
      while (ifc.md_busy && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      if (ifc.md_busy) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s timeout: md_busy still 1 after %0d cycles, required 0", name, cyc);
      end
   endtask

   task automatic run_md(input string name, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input int exp_cyc);
      int cyc;
      drive_r(f, a, b);
      @(negedge clk);
      idle_bus();
      wait_idle(name, cyc);
      check({name, " busy cycles"}, 64'(cyc), 64'(exp_cyc));
      check({name, " hi"}, 64'(ifc.hi), 64'(exp_hi));
      check({name, " lo"}, 64'(ifc.lo), 64'(exp_lo));
   endtask

   initial begin
      dec_vec_t dv[$];
      int       cyc;
      int       stall_bad;

      n_vec = 0;
      n_bad = 0;
      idle_bus();
      rst_n = 1'b0;

      dv.push_back(mk(1'b1, 4'b0000, 6'b000000, 4'b0100, 1'b0));
      dv.push_back(mk(1'b1, 4'b0001, 6'b000000, 4'b0101, 1'b0));
      dv.push_back(mk(1'b1, 4'b0011, 6'b000000, 4'b0000, 1'b0));
      dv.push_back(mk(1'b1, 4'b0100, 6'b000000, 4'b0001, 1'b0));
      dv.push_back(mk(1'b1, 4'b0101, 6'b000000, 4'b0110, 1'b0));
      dv.push_back(mk(1'b1, 4'b0110, 6'b000000, 4'b0010, 1'b0));
      dv.push_back(mk(1'b1, 4'b0111, 6'b000000, 4'b0111, 1'b0));
      dv.push_back(mk(1'b1, 4'b1000, 6'b000000, 4'b1111, 1'b1));
      dv.push_back(mk(1'b1, 4'b1101, 6'b100000, 4'b1111, 1'b1));
      dv.push_back(mk(1'b1, 4'b1111, 6'b000000, 4'b1111, 1'b1));
      dv.push_back(mk(1'b0, 4'b1001, 6'b000000, 4'b1111, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b100000, 4'b0100, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b100001, 4'b0100, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b100010, 4'b0101, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b100011, 4'b0101, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b100100, 4'b0000, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b100101, 4'b0001, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b100110, 4'b0010, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b100111, 4'b0011, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b101010, 4'b0110, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b101011, 4'b0111, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b000000, 4'b1000, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b000010, 4'b1001, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b000011, 4'b1010, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b010000, 4'b1011, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b010010, 4'b1100, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b010001, 4'b1111, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b010011, 4'b1111, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b011000, 4'b1111, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b011001, 4'b1111, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b011010, 4'b1111, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b011011, 4'b1111, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b111111, 4'b1111, 1'b1));
      dv.push_back(mk(1'b0, 4'b0010, 6'b111111, 4'b1111, 1'b0));
      dv.push_back(mk(1'b1, 4'b0010, 6'b000001, 4'b1111, 1'b1));

      // reset state, with an mflo presented so stall has a chance to be wrong
      repeat (2) @(negedge clk);
      drive_r(F_MFLO, '0, '0);
      #1;
      check("reset hi", 64'(ifc.hi), 64'h0);
      check("reset lo", 64'(ifc.lo), 64'h0);
      check("reset md_busy", 64'(ifc.md_busy), 64'h0);
      check("reset md_stall", 64'(ifc.md_stall), 64'h0);
      idle_bus();
      rst_n = 1'b1;
      @(negedge clk);

      // decode sweep; flush held so no mul/div or HI/LO move is accepted
      foreach (dv[i]) begin
         ifc.flush = 1'b1;
         ifc.valid = dv[i].valid;
         ifc.aluop = dv[i].aluop;
         ifc.funct = dv[i].funct;
         #1;
         check($sformatf("dec[%0d] alucontrol", i), 64'(ifc.alucontrol), 64'(dv[i].ac));
         check($sformatf("dec[%0d] illegal", i), 64'(ifc.illegal), 64'(dv[i].ill));
         @(negedge clk);
      end
      idle_bus();
      check("sweep md_busy", 64'(ifc.md_busy), 64'h0);

      // multu max with mflo waiting behind it
      drive_r(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      drive_r(F_MFLO, '0, '0);
      cyc       = 0;
      stall_bad = 0;
      while (ifc.md_busy && cyc < 200) begin
         #1;
         if (ifc.md_stall !== 1'b1) stall_bad++;
         cyc++;
         @(negedge clk);
      end
      #1;
      check("multu max busy cycles", 64'(cyc), 64'(MUL_CYC));
      check("mflo stall while busy", 64'(stall_bad), 64'h0);
      check("mflo stall after done", 64'(ifc.md_stall), 64'h0);
      check("multu max hi", 64'(ifc.hi), 64'hFFFF_FFFE);
      check("multu max lo", 64'(ifc.lo), 64'h0000_0001);
      idle_bus();

      run_md("mult -7x3",    F_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_CYC);
      run_md("mult 6x7",     F_MULT,  32'd6,         32'd7,         32'h0,         32'd42,        MUL_CYC);
      run_md("multu 2^16sq", F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0,         MUL_CYC);
      run_md("div -7/2",     F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC);
      run_md("div 7/-2",     F_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, DIV_CYC);
      run_md("divu 1000/7",  F_DIVU,  32'd1000,      32'd7,         32'd6,         32'd142,       DIV_CYC);
      run_md("divu 100/0",   F_DIVU,  32'd100,       32'h0,         32'd100,       32'hFFFF_FFFF, DIV_CYC);
      run_md("div -5/0",     F_DIV,   32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_CYC);
      run_md("div min/-1",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DIV_CYC);

      // HI/LO moves, then a divide killed by flush in its fifth busy cycle
      drive_r(F_MTHI, 32'h0000_1234, '0);
      @(negedge clk);
      drive_r(F_MTLO, 32'h0000_5678, '0);
      @(negedge clk);
      idle_bus();
      check("mthi hi", 64'(ifc.hi), 64'h1234);
      check("mtlo lo", 64'(ifc.lo), 64'h5678);
      drive_r(F_DIV, 32'd1000, 32'd3);
      @(negedge clk);
      idle_bus();
      repeat (4) @(negedge clk);
      drive_r(6'b100000, '0, '0);
      #1;
      check("add no stall while busy", 64'(ifc.md_stall), 64'h0);
      ifc.aluop = 4'b0000;
      ifc.funct = F_MFHI;
      #1;
      check("non-rtype no stall", 64'(ifc.md_stall), 64'h0);
      idle_bus();
      check("div busy before flush", 64'(ifc.md_busy), 64'h1);
      ifc.flush = 1'b1;
      @(negedge clk);
      ifc.flush = 1'b0;
      check("flush busy drop", 64'(ifc.md_busy), 64'h0);
      check("flush hi kept", 64'(ifc.hi), 64'h1234);
      check("flush lo kept", 64'(ifc.lo), 64'h5678);
      repeat (DIV_CYC + 2) @(negedge clk);
      check("flush no late hi", 64'(ifc.hi), 64'h1234);
      check("flush no late lo", 64'(ifc.lo), 64'h5678);

      // start and flush together: ignored; mthi under flush too
      drive_r(F_DIVU, 32'd9, 32'd2);
      ifc.flush = 1'b1;
      @(negedge clk);
      check("flush+start busy", 64'(ifc.md_busy), 64'h0);
      drive_r(F_MTHI, 32'h0000_AAAA, '0);
      @(negedge clk);
      idle_bus();
      check("flush+mthi hi", 64'(ifc.hi), 64'h1234);
      check("flush+start lo", 64'(ifc.lo), 64'h5678);

      // back-to-back multiplies: the second waits for busy to fall
      drive_r(F_MULTU, 32'd3, 32'd5);
      @(negedge clk);
      drive_r(F_MULTU, 32'd2, 32'd9);
      cyc = 0;
      #1;
      while (ifc.md_stall && cyc < 200) begin
         cyc++;
         @(negedge clk);
         #1;
      end
      check("b2b stall cycles", 64'(cyc), 64'(MUL_CYC));
      check("b2b first lo", 64'(ifc.lo), 64'd15);
      check("b2b idle between", 64'(ifc.md_busy), 64'h0);
      @(negedge clk);
      idle_bus();
      wait_idle("b2b second", cyc);
      check("b2b second cycles", 64'(cyc), 64'(MUL_CYC));
      check("b2b second hi", 64'(ifc.hi), 64'h0);
      check("b2b second lo", 64'(ifc.lo), 64'd18);

      // asynchronous reset in the middle of a divide
      drive_r(F_MTHI, 32'hDEAD_0001, '0);
      @(negedge clk);
      drive_r(F_DIV, 32'hFFFF_FF9C, 32'd7);
      @(negedge clk);
      idle_bus();
      repeat (9) @(negedge clk);
      check("pre-reset busy", 64'(ifc.md_busy), 64'h1);
      check("pre-reset hi", 64'(ifc.hi), 64'hDEAD_0001);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset hi", 64'(ifc.hi), 64'h0);
      check("async reset lo", 64'(ifc.lo), 64'h0);
      check("async reset busy", 64'(ifc.md_busy), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post-reset busy", 64'(ifc.md_busy), 64'h0);
      check("post-reset lo", 64'(ifc.lo), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_decode_muldiv.md
Name: alu_decode_muldiv

Overview:
- Next-generation EX-stage ALU control for the MIPS core.
- Decodes aluop/funct into a 4-bit alucontrol, extending the 3-bit set with xor/nor/sltu/shifts/HI-LO moves.
- Owns the HI/LO registers and a sequential multiply/divide engine.
- Drives a stall to the pipeline while a mul/div is in flight.

Parameters:
- WIDTH, 32: datapath width of src_a, src_b, hi and lo. Must be ≥ 8 and even.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  EX-stage instruction valid
- flush  in  1  kill the in-flight mul/div (pipeline flush)
- aluop  in  4  class from the main decoder
- funct  in  6  R-type funct field
- src_a  in  WIDTH  rs operand (dividend/multiplicand; mthi/mtlo source)
- src_b  in  WIDTH  rt operand (divisor/multiplier)
- alucontrol  out  4  ALU operation select (combinational)
- illegal  out  1  unknown aluop/funct while valid (combinational)
- md_stall  out  1  hold EX/earlier stages this cycle
- md_busy  out  1  engine running (registered)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- aluop encodings:
  - 0000 add, 0001 sub, 0010 R-type (use funct), 0011 and, 0100 or, 0101 slt, 0110 xor, 0111 sltu
  - any other value: illegal
- alucontrol encodings:
  - 0000 and, 0001 or, 0010 xor, 0011 nor, 0100 add, 0101 sub, 0110 slt, 0111 sltu
  - 1000 sll, 1001 srl, 1010 sra, 1011 pass_hi, 1100 pass_lo, 1111 none
- R-type funct mapping:
  - 100000/100001 add; 100010/100011 sub; 100100 and; 100101 or; 100110 xor; 100111 nor
  - 101010 slt; 101011 sltu; 000000 sll; 000010 srl; 000011 sra
  - 010000 mfhi → pass_hi; 010010 mflo → pass_lo
  - 010001 mthi, 010011 mtlo, 011000 mult, 011001 multu, 011010 div, 011011 divu → 1111
  - unknown funct → 1111 and illegal=1
- illegal is forced to 0 when valid=0. Decode is purely combinational; no x outputs ever.
- FSM states: IDLE, MUL, DIV.
- Start condition: IDLE & valid & !flush & mult/multu/div/divu.
  - On the start edge: latch operand magnitudes and sign flags, count←WIDTH, go to MUL or DIV, md_busy←1.
- Iteration: one bit per cycle (shift-add for MUL, restoring for DIV); count decrements.
  - Start at edge k → hi/lo written and md_busy←0 at edge k+WIDTH, FSM returns to IDLE on that same edge.
- Signed variants:
  - Operate on magnitudes, then negate at completion.
  - Product sign = sign_a^sign_b.
  - Quotient sign = sign_a^sign_b; remainder takes the sign of the dividend.
- Product: {hi,lo} = 2*WIDTH-bit result.
- Division: lo=quotient, hi=remainder.
  - Divide by zero: lo=all-ones (unsigned view), hi=src_a, for both div and divu; signed fixup is not applied.
  - div MIN/−1: lo=MIN, hi=0.
- mthi/mtlo: hi (or lo) ← src_a at the edge when valid & !md_busy & !flush.
- md_stall = md_busy & valid & funct ∈ {mfhi, mflo, mthi, mtlo, mult, multu, div, divu} (aluop=0010). Otherwise 0.
  - A second mul/div is held until IDLE and is accepted the cycle after md_busy falls.
- flush while busy: FSM→IDLE, md_busy←0 next edge, hi/lo keep their pre-op values.
- flush and start in the same cycle: start ignored.
- Reset (any time, including mid-operation): FSM IDLE, count 0, hi=0, lo=0, md_busy=0. md_stall therefore 0.

Optional Feature:
- Macro FAST_MUL_EN.
- Defined:
  - mult/multu use a single-cycle WIDTH×WIDTH multiplier; {hi,lo} written on the start edge itself.
  - md_busy never asserts for multiplies; the MUL state is unused.
  - div is unchanged.
- Undefined: iterative WIDTH-cycle multiply as specified above.

Decomposition:
- Package alu_pkg holds:
  - localparams for the aluop codes, funct codes and alucontrol codes
  - the FSM state enum (IDLE/MUL/DIV)
- Natural sub-module: md_iter_unit.
  - Contains the iterative shift-add/restoring datapath, counter and sign fixup.
  - Handshake: start/op in; done pulse plus hi/lo results out.
  - alu_decode_muldiv keeps the decode, HI/LO registers, stall and flush logic.

Test Plan:
- Decode sweep: aluop=0010 with every funct listed, plus aluops 0000–0111 → expected alucontrol. funct=111111 with valid=1 → alucontrol=1111, illegal=1; valid=0 → illegal=0.
- multu 0xFFFFFFFF×0xFFFFFFFF (WIDTH=32) → md_busy for exactly 32 cycles; then hi=0xFFFFFFFE, lo=0x00000001. mflo issued mid-op → md_stall=1 until done.
- mult −7×3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100/0 → lo=0xFFFFFFFF, hi=100. div 0x80000000/−1 → lo=0x80000000, hi=0.
- mthi 0x1234, then div started, flush at cycle 5 → md_busy drops next edge; hi=0x1234 unchanged. Back-to-back mult: second held until busy falls.
- rst_n pulsed low mid-divide → hi=lo=0 and md_busy=0 immediately (asynchronously). With FAST_MUL_EN defined: mult 6×7 → lo=42 one edge later, md_busy stays 0.
